// File: rtl/uart_rxfifo.sv
// Receive-side byte FIFO between the UART receiver and the CPU port.
// Every offered byte is drained at once; bytes that find the queue full are dropped and flagged.
module uart_rxfifo #(
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                clk,
   input  logic                resetq,
   input  logic                uart_valid,
   input  logic [7:0]          uart_data,
   output logic                uart_rd,
   input  logic                rd,
   input  logic                clr_overrun,
   output logic                valid,
   output logic [7:0]          data,
   output logic [DEPTH_LOG2:0] count,
   output logic                full,
   output logic                overrun
);

   localparam int                  DEPTH    = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

   logic [7:0]            mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wp;
   logic [DEPTH_LOG2-1:0] rp;
   logic [DEPTH_LOG2:0]   cnt;
   logic                  ovr;
   logic                  pop;
   logic                  accept;
   logic                  reject;

   // The receiver is always released, so a byte is never left waiting upstream.
   assign uart_rd = uart_valid;

   assign valid   = (cnt != '0);
   assign full    = (cnt == CNT_FULL);
   assign pop     = rd & valid;
   assign accept  = uart_valid & (~full | pop);
   assign reject  = uart_valid & full & ~pop;
   assign data    = valid ? mem[rp] : 8'h00;
   assign count   = cnt;
   assign overrun = ovr;

   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
         ovr <= 1'b0;
      end else begin
         if (accept)
            wp <= wp + 1'b1;
         if (pop)
            rp <= rp + 1'b1;
         if (accept & ~pop)
            cnt <= cnt + 1'b1;
         else if (pop & ~accept)
            cnt <= cnt - 1'b1;
         // A dropped byte outranks a simultaneous clear so the loss is never hidden.
         if (reject)
            ovr <= 1'b1;
         else if (clr_overrun)
            ovr <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (accept)
         mem[wp] <= uart_data;
   end

endmodule
